// File: rtl/lsu_dmem.sv
// Multi-cycle load/store data memory: valid/ready request, WAIT_STATES delay, one-cycle response.
// Define LSU_DMEM_STATS_EN to add the ld_cnt/st_cnt/err_cnt counters.
module lsu_dmem #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
`ifdef LSU_DMEM_STATS_EN
    ,
    output logic [31:0]     ld_cnt,
    output logic [31:0]     st_cnt,
    output logic [31:0]     err_cnt
`endif
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;

    logic             q_we, q_uns, err_q;
    logic [1:0]       q_size;
    logic [IDX_W-1:0] q_idx;
    logic [OFF_W-1:0] q_off;
    logic [XLEN-1:0]  q_wdata, rdata;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic             accept, acc_err, do_access, in_idle;
    logic             a_we, a_uns;
    logic [1:0]       a_size;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off, off_h, off_w;
    logic [XLEN-1:0]  a_wdata, row, wdat, ld_data;
    logic [NBYTES-1:0] be;
    logic [7:0]       b8;
    logic [15:0]      h16;
    logic [31:0]      w32;

    assign in_idle   = (state == IDLE);
    assign req_ready = in_idle;
    assign accept    = req_valid && in_idle;
    assign rsp_valid = (state == RESP);
    assign rsp_err   = err_q && rsp_valid;
    assign rsp_rdata = rdata;

    // Address bits above the word index must be zero for the access to be in range.
    assign acc_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (|req_addr[XLEN-1:OFF_W+IDX_W]);

    // With zero wait states the access happens on the accept edge, so use the live request.
    assign a_we    = in_idle ? req_we                    : q_we;
    assign a_uns   = in_idle ? req_unsigned              : q_uns;
    assign a_size  = in_idle ? req_size                  : q_size;
    assign a_idx   = in_idle ? req_addr[OFF_W +: IDX_W]  : q_idx;
    assign a_off   = in_idle ? req_addr[OFF_W-1:0]       : q_off;
    assign a_wdata = in_idle ? req_wdata                 : q_wdata;

    assign do_access = (WAIT_STATES == 0) ? (accept && !acc_err)
                                          : (state == WAIT && cnt == 4'd0);

    assign off_h = a_off & ~OFF_W'(1);
    assign off_w = a_off & ~OFF_W'(3);
    assign row   = mem[a_idx];
    assign b8    = 8'(row >> {a_off, 3'b000});
    assign h16   = 16'(row >> {off_h, 3'b000});
    assign w32   = 32'(row >> {off_w, 3'b000});

    always_comb begin
        ld_data = '0;
        be      = '0;
        wdat    = '0;
        unique case (a_size)
            2'b00: begin
                ld_data = a_uns ? XLEN'(b8) : XLEN'($signed(b8));
                be      = NBYTES'(1) << a_off;
                wdat    = {NBYTES{a_wdata[7:0]}};
            end
            2'b01: begin
                ld_data = a_uns ? XLEN'(h16) : XLEN'($signed(h16));
                be      = NBYTES'(3) << off_h;
                wdat    = {(NBYTES/2){a_wdata[15:0]}};
            end
            default: begin
                ld_data = a_uns ? XLEN'(w32) : XLEN'($signed(w32));
                be      = NBYTES'(15) << off_w;
                wdat    = {(XLEN/32){a_wdata[31:0]}};
            end
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (accept) begin
                if (acc_err || WAIT_STATES == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: if (cnt == 4'd0) state_d = RESP;
                  else             cnt_d   = cnt - 4'd1;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            q_we    <= 1'b0;
            q_uns   <= 1'b0;
            q_size  <= '0;
            q_idx   <= '0;
            q_off   <= '0;
            q_wdata <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                q_we    <= req_we;
                q_uns   <= req_unsigned;
                q_size  <= req_size;
                q_idx   <= req_addr[OFF_W +: IDX_W];
                q_off   <= req_addr[OFF_W-1:0];
                q_wdata <= req_wdata;
                err_q   <= acc_err;
                if (acc_err) rdata <= '0;
            end
            if (do_access) rdata <= a_we ? '0 : ld_data;
        end
    end

    // Storage is deliberately not reset; do_access is low while in reset, so no pending store lands.
    always_ff @(posedge clk) begin
        if (do_access && a_we) begin
            for (int b = 0; b < NBYTES; b++)
                if (be[b]) mem[a_idx][8*b +: 8] <= wdat[8*b +: 8];
        end
    end

`ifdef LSU_DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt  <= '0;
            st_cnt  <= '0;
            err_cnt <= '0;
        end else if (state == RESP) begin
            if (err_q)     err_cnt <= err_cnt + 32'd1;
            else if (q_we) st_cnt  <= st_cnt + 32'd1;
            else           ld_cnt  <= ld_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dmem.sv
// Scoreboard bench for lsu_dmem: byte-array reference model, decoupled negedge response monitor.
module tb_lsu_dmem;
    localparam int WS    = 3;
    localparam int DEPTH = 64;
    localparam int NB    = DEPTH * 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
`ifdef LSU_DMEM_STATS_EN
    logic [31:0] ld_cnt, st_cnt, err_cnt;
`endif

    lsu_dmem #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef LSU_DMEM_STATS_EN
        , .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [NB];
    int         checks = 0, failures = 0;
    int         last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: memory is a flat little-endian byte array; an access touches 2**size bytes.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int n;
        rd  = '0;
        err = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0) || (a >= NB);
        if (err) return;
        n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            if (we) mem_m[a + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = mem_m[a + i];
        end
        if (!we && !uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
    endfunction

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit drop);
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        int          w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high addr=%h", a);
            req_valid = 1'b0;
            return;
        end
        if (!drop) begin
            model(we, sz, uns, a, wd, rd, er);
            e.rdata = rd; e.err = er; e.t0 = cyc; e.lat = er ? 1 : WS + 1;
            exp_q.push_back(e);
        end
        last_acc = cyc;
        @(posedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rsp actual=rsp_valid rdata=%h err=%b required=no_rsp", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          prev;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) issue(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b0);

        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 0);
        issue(0, 2'b00, 0, 32'h13, 0, 0);
        issue(0, 2'b00, 1, 32'h13, 0, 0);
        issue(0, 2'b01, 0, 32'h12, 0, 0);
        issue(0, 2'b01, 1, 32'h10, 0, 0);
        issue(1, 2'b00, 0, 32'h11, 32'h55, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 0);
        issue(0, 2'b10, 0, 32'h12, 0, 0);
        issue(1, 2'b01, 0, 32'h11, 32'hBEEF, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 0);
        issue(0, 2'b10, 0, 32'(NB), 0, 0);
        issue(0, 2'b11, 0, 32'h10, 0, 0);
        issue(1, 2'b10, 0, 32'(NB + 4), 32'hCAFEF00D, 0);
        issue(0, 2'b00, 1, 32'(NB - 1), 0, 0);
        issue(1, 2'b10, 0, 32'h8000_0010, 32'h0BAD0BAD, 0);
        issue(0, 2'b10, 0, 32'h10, 0, 0);
        drain();

        // Back-to-back with req_valid held high: accepts must be WS+2 cycles apart.
        issue(0, 2'b10, 0, 32'h10, 0, 0);
        prev = last_acc;
        for (int k = 0; k < 3; k++) begin
            issue(0, 2'b10, 0, 32'(4 * k), 0, 0);
            chk("accept_spacing", last_acc - prev, WS + 2);
            prev = last_acc;
        end
        drain();

        // Reset during WAIT: outputs clear asynchronously and the store never commits.
        issue(0, 2'b10, 0, 32'h10, 0, 0);
        drain();
        issue(1, 2'b10, 0, 32'h20, 32'h12345678, 1);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("midrst_req_ready", {31'b0, req_ready}, 1);
        chk("midrst_rsp_rdata", rsp_rdata, 0);
        chk("midrst_rsp_err", {31'b0, rsp_err}, 0);
`ifdef LSU_DMEM_STATS_EN
        chk("midrst_st_cnt", st_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 2'b10, 0, 32'h20, 0, 0);
        drain();

        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, NB + 15));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
